// File: rtl/conv_mem_ctrl_pkg.sv
// Shared definitions for the convolution line-memory bank controller:
// mode encodings, a clog2 helper and the block-counter width.
package conv_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_LOAD = 2'b00,
        MODE_PROC = 2'b01,
        MODE_OUT  = 2'b10,
        MODE_HOLD = 2'b11
    } mode_t;

    localparam int BLKCNT_W = 16;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/conv_mem_ctrl_rise_det.sv
// Single-flop rising-edge detector with synchronous active-high reset.
module rise_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/conv_mem_ctrl.sv
// Bank controller for N+K-1 line memories across LOAD/PROC/OUT/HOLD phases.
// Optional accepted-edge counter enabled by CONV_MEM_CTRL_BLKCNT_EN.
module conv_mem_ctrl
    import conv_mem_ctrl_pkg::*;
#(
    parameter  int N     = 16,
    parameter  int K     = 3,
    parameter  int SUB   = N / 2 + 1,
    localparam int BANKS = N + K - 1,
    localparam int SELW  = clog2(BANKS),
    localparam int SUBW  = (clog2(SUB) < 1) ? 1 : clog2(SUB)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_sop,
    input  logic                i_eop,
    input  logic                i_chblk,
    output logic [1:0]          o_state,
    output logic [SUBW-1:0]     o_substate,
    output logic [BANKS-1:0]    o_we,
    output logic [SELW-1:0]     o_mem_select,
    output logic                o_err,
    output logic [BLKCNT_W-1:0] o_blk_cnt
);

    mode_t            mode;
    mode_t            state;
    logic             chblk_rise;
    logic             transition;
    logic             accept;
    logic             enter_out;
    logic [SUBW-1:0]  substate;
    logic [BANKS-1:0] we_load;
    logic [BANKS-1:0] proc_mask;
    logic [SELW-1:0]  sel_load;
    logic [SELW-1:0]  proc_base;
    logic [SELW-1:0]  sel_out;

    assign mode       = mode_t'({i_eop, i_sop});
    assign transition = (mode != state);
    assign accept     = chblk_rise & ~transition & (state != MODE_HOLD);
    assign enter_out  = (mode == MODE_OUT) && (state != MODE_OUT);

    rise_det u_rise_det (
        .clk  (clk),
        .rst  (rst),
        .d    (i_chblk),
        .rise (chblk_rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MODE_LOAD;
        end else begin
            state <= mode;
        end
    end

    // Only the active phase's registers move; everything else holds so each
    // phase resumes exactly where it left off.
    always_ff @(posedge clk) begin
        if (rst) begin
            substate  <= '0;
            we_load   <= BANKS'(1);
            proc_mask <= {{(K-1){1'b0}}, {N{1'b1}}};
            sel_load  <= '0;
            proc_base <= '0;
            sel_out   <= '0;
        end else begin
            if (enter_out) begin
                substate <= (substate == SUBW'(SUB - 1)) ? '0 : substate + 1'b1;
            end
            if (accept) begin
                case (state)
                    MODE_LOAD: begin
                        we_load  <= {we_load[BANKS-2:0], we_load[BANKS-1]};
                        sel_load <= (sel_load == SELW'(BANKS - 1)) ? '0 : sel_load + 1'b1;
                    end
                    MODE_PROC: begin
                        proc_mask <= {proc_mask[K-2:0], proc_mask[BANKS-1:K-1]};
                        proc_base <= (proc_base >= SELW'(K - 1)) ?
                                     proc_base - SELW'(K - 1) :
                                     proc_base + SELW'(BANKS - K + 1);
                    end
                    MODE_OUT: begin
                        sel_out <= (sel_out == SELW'(BANKS - 1)) ? '0 : sel_out + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef CONV_MEM_CTRL_BLKCNT_EN
    logic [BLKCNT_W-1:0] blk_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_cnt <= '0;
        end else if ((mode == MODE_LOAD) && (state != MODE_LOAD)) begin
            blk_cnt <= '0;
        end else if (accept) begin
            blk_cnt <= blk_cnt + 1'b1;
        end
    end

    assign o_blk_cnt = blk_cnt;
`else
    assign o_blk_cnt = '0;
`endif

    always_comb begin
        o_we         = '0;
        o_mem_select = '0;
        o_err        = 1'b0;
        case (state)
            MODE_LOAD: begin
                o_we         = we_load;
                o_mem_select = sel_load;
            end
            MODE_PROC: begin
                o_we         = proc_mask;
                o_mem_select = proc_base;
            end
            MODE_OUT: begin
                o_mem_select = sel_out;
            end
            default: begin
                o_err = 1'b1;
            end
        endcase
    end

    assign o_state    = state;
    assign o_substate = substate;

endmodule

// File: tb/tb_conv_mem_ctrl.sv
// Directed bench for conv_mem_ctrl at defaults (N=16, K=3, BANKS=18, SUB=9);
// expected counter values follow CONV_MEM_CTRL_BLKCNT_EN.
module tb_conv_mem_ctrl;

    typedef struct packed {
        logic [1:0]  st;
        logic [3:0]  sub;
        logic [17:0] we;
        logic [4:0]  sel;
        logic        err;
        logic [15:0] cnt;
    } obs_t;

    logic        clk;
    logic        rst;
    logic        i_sop;
    logic        i_eop;
    logic        i_chblk;
    logic [1:0]  o_state;
    logic [3:0]  o_substate;
    logic [17:0] o_we;
    logic [4:0]  o_mem_select;
    logic        o_err;
    logic [15:0] o_blk_cnt;

    obs_t  exp_q[$];
    string name_q[$];
    int    vectors;
    int    miscompares;

    conv_mem_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .i_sop        (i_sop),
        .i_eop        (i_eop),
        .i_chblk      (i_chblk),
        .o_state      (o_state),
        .o_substate   (o_substate),
        .o_we         (o_we),
        .o_mem_select (o_mem_select),
        .o_err        (o_err),
        .o_blk_cnt    (o_blk_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input logic [1:0] m);
        {i_eop, i_sop} = m;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        i_chblk = 1'b0;
        set_mode(2'b00);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse();
        i_chblk = 1'b1;
        tick();
        i_chblk = 1'b0;
        tick();
    endtask

    task automatic expect_obs(input string name, input logic [1:0] st, input logic [3:0] sub,
                              input logic [17:0] we, input logic [4:0] sel, input logic err,
                              input logic [15:0] cnt);
        obs_t e;
        e.st  = st;
        e.sub = sub;
        e.we  = we;
        e.sel = sel;
        e.err = err;
`ifdef CONV_MEM_CTRL_BLKCNT_EN
        e.cnt = cnt;
`else
        e.cnt = 16'd0;
`endif
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    // scoreboard monitor: samples on the falling edge, away from updates
    always @(negedge clk) begin
        obs_t  e;
        obs_t  a;
        string n;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = '{st: o_state, sub: o_substate, we: o_we, sel: o_mem_select,
                  err: o_err, cnt: o_blk_cnt};
            vectors = vectors + 1;
            if (a !== e) begin
                miscompares = miscompares + 1;
                $display("FAIL %s: got st=%b sub=%0d we=%h sel=%0d err=%b cnt=%0d, want st=%b sub=%0d we=%h sel=%0d err=%b cnt=%0d",
                         n, a.st, a.sub, a.we, a.sel, a.err, a.cnt,
                         e.st, e.sub, e.we, e.sel, e.err, e.cnt);
            end
        end
    end

    initial begin
        int wait_cycles;
        vectors     = 0;
        miscompares = 0;
        rst     = 1'b1;
        i_sop   = 1'b0;
        i_eop   = 1'b0;
        i_chblk = 1'b0;

        // reset state
        do_reset();
        expect_obs("reset", 2'b00, 4'd0, 18'h00001, 5'd0, 1'b0, 16'd0);

        // LOAD rotation: 20 pulses, wraps bit17 -> bit0
        for (int k = 1; k <= 20; k++) begin
            pulse();
            if (k == 17 || k == 18 || k == 20) begin
                expect_obs("load_rot", 2'b00, 4'd0, 18'h00001 << (k % 18), 5'(k % 18), 1'b0, 16'(k));
            end
        end
        expect_obs("load_final", 2'b00, 4'd0, 18'h00004, 5'd2, 1'b0, 16'd20);

        // PROC rotation
        do_reset();
        set_mode(2'b01);
        tick();
        expect_obs("proc_enter", 2'b01, 4'd0, 18'h0FFFF, 5'd0, 1'b0, 16'd0);
        pulse();
        expect_obs("proc_p1", 2'b01, 4'd0, 18'h33FFF, 5'd16, 1'b0, 16'd1);
        pulse();
        expect_obs("proc_p2", 2'b01, 4'd0, 18'h3CFFF, 5'd14, 1'b0, 16'd2);
        for (int k = 3; k <= 9; k++) pulse();
        expect_obs("proc_p9", 2'b01, 4'd0, 18'h0FFFF, 5'd0, 1'b0, 16'd9);

        // OUT substate wrap, alternating OUT/LOAD
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            set_mode(2'b10);
            tick();
            expect_obs("out_sub", 2'b10, 4'(k % 9), 18'h0, 5'd0, 1'b0, 16'd0);
            set_mode(2'b00);
            tick();
            expect_obs("out_back_load", 2'b00, 4'(k % 9), 18'h00001, 5'd0, 1'b0, 16'd0);
        end
        // OUT select advance, then PROC untouched
        set_mode(2'b10);
        tick();
        pulse();
        pulse();
        expect_obs("out_sel", 2'b10, 4'd2, 18'h0, 5'd2, 1'b0, 16'd2);
        set_mode(2'b01);
        tick();
        expect_obs("proc_isolated", 2'b01, 4'd2, 18'h0FFFF, 5'd0, 1'b0, 16'd2);

        // edge rules: edge coincident with mode change is dropped
        do_reset();
        set_mode(2'b01);
        i_chblk = 1'b1;
        tick();
        tick();
        i_chblk = 1'b0;
        tick();
        expect_obs("edge_on_transition", 2'b01, 4'd0, 18'h0FFFF, 5'd0, 1'b0, 16'd0);
        // held high in LOAD counts once
        set_mode(2'b00);
        tick();
        tick();
        i_chblk = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        i_chblk = 1'b0;
        tick();
        expect_obs("held_chblk", 2'b00, 4'd0, 18'h00002, 5'd1, 1'b0, 16'd1);

        // HOLD freezes everything
        do_reset();
        pulse();
        pulse();
        pulse();
        expect_obs("hold_pre", 2'b00, 4'd0, 18'h00008, 5'd3, 1'b0, 16'd3);
        set_mode(2'b11);
        tick();
        expect_obs("hold_enter", 2'b11, 4'd0, 18'h0, 5'd0, 1'b1, 16'd3);
        pulse();
        pulse();
        expect_obs("hold_pulses", 2'b11, 4'd0, 18'h0, 5'd0, 1'b1, 16'd3);
        set_mode(2'b00);
        tick();
        expect_obs("hold_exit", 2'b00, 4'd0, 18'h00008, 5'd3, 1'b0, 16'd0);

        // counter and reset mid-operation
        do_reset();
        set_mode(2'b01);
        tick();
        for (int k = 0; k < 5; k++) pulse();
        expect_obs("proc_5", 2'b01, 4'd0, 18'h3FF3F, 5'd8, 1'b0, 16'd5);
        rst     = 1'b1;
        i_chblk = 1'b1;
        tick();
        expect_obs("mid_reset", 2'b00, 4'd0, 18'h00001, 5'd0, 1'b0, 16'd0);
        rst     = 1'b0;
        i_chblk = 1'b0;
        set_mode(2'b00);
        tick();

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            tick();
            wait_cycles = wait_cycles + 1;
        end
        if (exp_q.size() > 0) begin
            miscompares = miscompares + 1;
            $display("FAIL drain: %0d expected vectors left, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/conv_mem_ctrl.md
# conv_mem_ctrl

Parametrised memory-bank controller for the 2D convolution datapath. It drives write enables and read/write bank selects for `N+K-1` line memories, with `N` parallel output lanes and a `K`×`K` kernel, across the LOAD / PROC / OUT phases announced by the frame-sequencing logic. It adds the following over the previous fixed-size controller:
- registered phase tracking;
- configurable kernel size and substate count;
- an explicit illegal-mode state.

## Interface
- `N`, 16: parallel lanes; even, ≥2.
- `K`, 3: kernel size; odd, 3..N+1.
- `SUB`, N/2+1: number of OUT addressing substates.
- Derived localparams: `BANKS = N+K-1`, `SELW = clog2(BANKS)`, `SUBW = clog2(SUB)`.

Ports (clock and reset first):
- `clk` in 1: clock.
- `rst` in 1: reset rst, synchronous, active-high; clock clk.
- `i_sop` in 1: mode bit 0.
- `i_eop` in 1: mode bit 1.
- `i_chblk` in 1: block-change level; each rising edge advances the active phase.
- `o_state` out 2: registered mode, 00 LOAD, 01 PROC, 10 OUT, 11 HOLD.
- `o_substate` out SUBW: OUT addressing substate.
- `o_we` out BANKS: bank write enables.
- `o_mem_select` out SELW: bank index for the current phase.
- `o_err` out 1: high while in HOLD.
- `o_blk_cnt` out 16: accepted-edge count; see Configuration.

## Operation
- **Mode and state.**
  - `mode = {i_eop, i_sop}` is sampled every clock; `state <= mode`.
  - A clock where `mode != state` is a transition clock.
- **Edge detection.**
  - `chblk_q <= i_chblk`; `edge = i_chblk & ~chblk_q`.
  - An edge is accepted only if it occurs on a non-transition clock and `state != HOLD`. Otherwise it is dropped permanently.
- **LOAD.**
  - `we_load` is one-hot. Each accepted edge rotates it left by 1, so bit `BANKS-1` wraps to bit 0.
  - `sel_load` increments mod `BANKS`.
  - Outputs: `o_we = we_load`, `o_mem_select = sel_load`.
- **PROC.**
  - `proc_mask` holds `N` ones and `K-1` zeros.
  - Each accepted edge rotates it right by `K-1`: `new[i] = old[(i+K-1) mod BANKS]`.
  - `proc_base` = (`proc_base` − (K−1)) mod `BANKS`, which is the first bank of the enabled window.
  - Outputs: `o_we = proc_mask`, `o_mem_select = proc_base`.
- **OUT.**
  - On the transition clock into OUT, `substate` increments, wrapping from `SUB-1` to 0.
  - Each accepted edge increments `sel_out` mod `BANKS`.
  - Outputs: `o_we = 0`, `o_mem_select = sel_out`.
- **HOLD** (mode 11).
  - Outputs: `o_we = 0`, `o_mem_select = 0`, `o_err = 1`.
  - All status registers are frozen. Leaving HOLD resumes from the frozen values.
- **Phase isolation.** Status registers of inactive phases never change. Each phase resumes where it left off.
- **Output decode.** `o_we` and `o_mem_select` are a combinational decode of the registered `state` and the status registers. No path exists from inputs to outputs.

## Timing
- **Reset values:**
  - `state = LOAD`, `chblk_q = 0`, `substate = 0`.
  - `we_load = 1` (bit 0).
  - `proc_mask` = ones in bits `[N-1:0]`, zeros elsewhere.
  - `proc_base`, `sel_load`, `sel_out` = 0; `blk_cnt` = 0.
  - Resulting outputs: `o_state = 00`, `o_we = 1`, `o_mem_select = 0`, `o_substate = 0`, `o_err = 0`, `o_blk_cnt = 0`.
- **Mode latency:** a change on `i_sop`/`i_eop` at clock t is reflected on all outputs after clock t, i.e. 1 cycle.
- **Edge latency:** `i_chblk` rising, sampled high at clock t with `chblk_q = 0`, updates the status register at t. The output change is visible after t.
- **Held chblk:** `i_chblk` held high counts once. Back-to-back edges need `i_chblk` low for at least 1 clock between them.
- **Simultaneous events:** an edge and a mode change on the same clock → edge dropped; the new state is taken.
- **Reset mid-operation:** `rst` overrides every other input; all registers return to reset values on that clock.

## Configuration
- Macro: `CONV_MEM_CTRL_BLKCNT_EN`.
- **Defined:**
  - `blk_cnt` increments by 1 on every accepted edge in any phase, wrapping at 16 bits.
  - It clears on reset and on every transition clock into LOAD.
  - `o_blk_cnt = blk_cnt`.
- **Undefined:** no counter logic; `o_blk_cnt` tied to 0. The port is always present.

## Structure
- **Package `conv_mem_ctrl_pkg`:**
  - mode encodings `MODE_LOAD = 2'b00`, `MODE_PROC = 2'b01`, `MODE_OUT = 2'b10`, `MODE_HOLD = 2'b11`;
  - `clog2` function;
  - `blk_cnt` width constant (16).
- **Sub-module `rise_det`:** a single-flop rising-edge detector with synchronous reset. It produces `edge`; the qualification with transition/HOLD stays in the top.

## Test plan
Bench uses defaults: N=16, K=3, BANKS=18, SUB=9.
1. **LOAD rotation:** reset, mode 00, 20 isolated `i_chblk` pulses → `o_we` steps bit0→bit17→bit0; final `o_we = 0x00004`, `o_mem_select = 2`.
2. **PROC rotation:** reset, mode 01, wait 1 clock, one pulse → `o_we = 0x33FFF`, `o_mem_select = 16`. Nine total pulses → mask returns to `0x0FFFF`, `o_mem_select = 0`.
3. **OUT substate wrap:** alternate OUT/LOAD 10 times with no pulses → `o_substate` reads 1..8, 0, 1. `o_we = 0` in every OUT.
4. **Edge rules:** `i_chblk` rises on the clock `i_sop` changes 0→1 → no PROC update. `i_chblk` held high for 10 clocks in LOAD → exactly one advance.
5. **HOLD:** LOAD with 3 edges, then mode 11 with 2 pulses → `o_err = 1`, `o_we = 0`. Return to 00 → `o_we = 0x00008`, `o_err = 0`.
6. **Reset and counter:** with `CONV_MEM_CTRL_BLKCNT_EN` defined, 5 PROC edges → `o_blk_cnt = 5`. Then `rst` for 1 clock → all reset values, including `o_blk_cnt = 0`.
